fixed_vec_accumulator: RTL and testbench

FIXED_VEC_ACCUMULATOR -- requirements
Module: fixed_vec_accumulator

---
 rtl/fixed_vec_accumulator.sv | 134 +++++++++++++
 tb/tb_fixed_vec_accumulator.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_vec_accumulator.sv
// fixed_vec_accumulator
// Sums a run of signed input vectors lane by lane. Each lane is accumulated
// independently and can either wrap or saturate. A finished block is held
// on data_out until downstream takes it, and the next block can start in
// that same cycle.
//
// Handshake: a beat moves on an interface only in a cycle where its valid
// and ready are both high at the rising edge. A source holds its data
// stable while valid is high and ready is low. On the input side, ready
// depends on clear, the block state and data_out_ready, and never on
// data_in_valid. On the output side, data_out_valid stays high with
// data_out stable until data_out_ready is seen high.
module fixed_vec_accumulator #(
  parameter int IN_WIDTH  = 16,
  parameter int IN_SIZE   = 4,
  parameter int MAX_DEPTH = 8,
  parameter int OUT_WIDTH = IN_WIDTH + $clog2(MAX_DEPTH),
  parameter int SATURATE  = 0,
  parameter int CNT_WIDTH = $clog2(MAX_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CNT_WIDTH-1:0]          depth,
  input  logic                          clear,
  input  logic [IN_SIZE*IN_WIDTH-1:0]   data_in,
  input  logic                          data_in_valid,
  output logic                          data_in_ready,
  output logic [IN_SIZE*OUT_WIDTH-1:0]  data_out,
  output logic                          data_out_valid,
  input  logic                          data_out_ready,
  output logic [IN_SIZE-1:0]            overflow,
  output logic [CNT_WIDTH-1:0]          counter
);

  typedef enum logic {
    S_ACC  = 1'b0,
    S_FULL = 1'b1
  } state_e;

  localparam logic [CNT_WIDTH-1:0] MAX_D   = CNT_WIDTH'(MAX_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_D   = CNT_WIDTH'(1);
  // Signed range limits of a lane, written at the widened sum width.
  localparam logic [OUT_WIDTH:0]   SUM_MAX = {2'b00, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH:0]   SUM_MIN = {2'b11, {(OUT_WIDTH-1){1'b0}}};

  state_e                             state_q, state_d;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0]  sum_q, sum_d;
  logic [IN_SIZE-1:0]                 ovf_q, ovf_d;
  logic [CNT_WIDTH-1:0]               cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]               eff_q, eff_d;

  logic                               full;
  logic                               accept;
  logic [CNT_WIDTH-1:0]               depth_clamped;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0]  base_sum;
  logic [IN_SIZE-1:0][OUT_WIDTH:0]    wide;
  logic [IN_SIZE-1:0][OUT_WIDTH-1:0]  add_res;
  logic [IN_SIZE-1:0]                 add_ovf;

  assign full          = (state_q == S_FULL);
  assign data_in_ready = !clear && (!full || data_out_ready);
  assign accept        = data_in_valid && data_in_ready;
  assign depth_clamped = (depth == '0)   ? ONE_D :
                         (depth > MAX_D) ? MAX_D : depth;

  // Per-lane adder: a beat taken while FULL seeds a new block, so it adds to zero.
  always_comb begin
    base_sum = '0;
    wide     = '0;
    add_res  = '0;
    add_ovf  = '0;
    for (int i = 0; i < IN_SIZE; i++) begin
      base_sum[i] = full ? '0 : sum_q[i];
      wide[i] = {base_sum[i][OUT_WIDTH-1], base_sum[i]} +
                {{(OUT_WIDTH+1-IN_WIDTH){data_in[i*IN_WIDTH+IN_WIDTH-1]}},
                 data_in[i*IN_WIDTH +: IN_WIDTH]};
      add_ovf[i] = wide[i][OUT_WIDTH] != wide[i][OUT_WIDTH-1];
      if (SATURATE != 0 && add_ovf[i]) begin
        add_res[i] = wide[i][OUT_WIDTH] ? SUM_MIN[OUT_WIDTH-1:0]
                                        : SUM_MAX[OUT_WIDTH-1:0];
      end else begin
        add_res[i] = wide[i][OUT_WIDTH-1:0];
      end
    end
  end

  // Next-state logic: clear first, then an accepted beat, then a drain with no new beat.
  always_comb begin
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    eff_d   = eff_q;
    if (clear) begin
      sum_d = '0;
      ovf_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      sum_d = add_res;
      ovf_d = (full ? '0 : ovf_q) | add_ovf;
      cnt_d = full ? ONE_D : cnt_q + ONE_D;
      if (full || cnt_q == '0) begin
        eff_d = depth_clamped;
      end
    end else if (full && data_out_ready) begin
      sum_d = '0;
      ovf_d = '0;
      cnt_d = '0;
    end
    state_d = (cnt_d == eff_d) ? S_FULL : S_ACC;
  end

  // State registers; reset leaves an empty block with a depth of one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_ACC;
      sum_q   <= '0;
      ovf_q   <= '0;
      cnt_q   <= '0;
      eff_q   <= ONE_D;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      eff_q   <= eff_d;
    end
  end

  assign data_out       = sum_q;
  assign data_out_valid = full;
  assign overflow       = ovf_q;
  assign counter        = cnt_q;

endmodule

// File: tb/tb_fixed_vec_accumulator.sv
// Bench for fixed_vec_accumulator: four instances share one stimulus stream.
//   0: 8-bit x2 lanes, MAX_DEPTH 4, OUT_WIDTH 10, wrap
//   1: 8-bit x2 lanes, MAX_DEPTH 8, OUT_WIDTH 11, wrap
//   2: 8-bit x2 lanes, MAX_DEPTH 4, OUT_WIDTH 8,  saturate
//   3: 8-bit x2 lanes, MAX_DEPTH 4, OUT_WIDTH 8,  wrap
// An integer model predicts every instance each cycle. Directed literal
// expectations pin the model on hand-computed cases.
module tb_fixed_vec_accumulator;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  depth = 4'd4;
  logic [2:0]  depth_n;
  logic        clear = 1'b0;
  logic [15:0] data_in = '0;
  logic        valid = 1'b0;
  logic        out_ready = 1'b1;

  // Instances with a 3-bit depth port see depths above 7 as 7 (still above their MAX_DEPTH).
  assign depth_n = (depth > 4'd7) ? 3'd7 : depth[2:0];

  logic [19:0] a_dout; logic a_vld, a_rdy; logic [1:0] a_ovf; logic [2:0] a_cnt;
  logic [21:0] b_dout; logic b_vld, b_rdy; logic [1:0] b_ovf; logic [3:0] b_cnt;
  logic [15:0] c_dout; logic c_vld, c_rdy; logic [1:0] c_ovf; logic [2:0] c_cnt;
  logic [15:0] d_dout; logic d_vld, d_rdy; logic [1:0] d_ovf; logic [2:0] d_cnt;

  fixed_vec_accumulator #(.IN_WIDTH(8), .IN_SIZE(2), .MAX_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .depth(depth_n), .clear(clear), .data_in(data_in),
    .data_in_valid(valid), .data_in_ready(a_rdy), .data_out(a_dout),
    .data_out_valid(a_vld), .data_out_ready(out_ready), .overflow(a_ovf), .counter(a_cnt));

  fixed_vec_accumulator #(.IN_WIDTH(8), .IN_SIZE(2), .MAX_DEPTH(8)) u_b (
    .clk(clk), .rst(rst), .depth(depth), .clear(clear), .data_in(data_in),
    .data_in_valid(valid), .data_in_ready(b_rdy), .data_out(b_dout),
    .data_out_valid(b_vld), .data_out_ready(out_ready), .overflow(b_ovf), .counter(b_cnt));

  fixed_vec_accumulator #(.IN_WIDTH(8), .IN_SIZE(2), .MAX_DEPTH(4), .OUT_WIDTH(8), .SATURATE(1)) u_c (
    .clk(clk), .rst(rst), .depth(depth_n), .clear(clear), .data_in(data_in),
    .data_in_valid(valid), .data_in_ready(c_rdy), .data_out(c_dout),
    .data_out_valid(c_vld), .data_out_ready(out_ready), .overflow(c_ovf), .counter(c_cnt));

  fixed_vec_accumulator #(.IN_WIDTH(8), .IN_SIZE(2), .MAX_DEPTH(4), .OUT_WIDTH(8), .SATURATE(0)) u_d (
    .clk(clk), .rst(rst), .depth(depth_n), .clear(clear), .data_in(data_in),
    .data_in_valid(valid), .data_in_ready(d_rdy), .data_out(d_dout),
    .data_out_valid(d_vld), .data_out_ready(out_ready), .overflow(d_ovf), .counter(d_cnt));

  logic [63:0] o_dout [4];
  logic        o_vld  [4];
  logic        o_rdy  [4];
  logic [1:0]  o_ovf  [4];
  logic [3:0]  o_cnt  [4];
  assign o_dout[0] = 64'(a_dout); assign o_vld[0] = a_vld; assign o_rdy[0] = a_rdy;
  assign o_dout[1] = 64'(b_dout); assign o_vld[1] = b_vld; assign o_rdy[1] = b_rdy;
  assign o_dout[2] = 64'(c_dout); assign o_vld[2] = c_vld; assign o_rdy[2] = c_rdy;
  assign o_dout[3] = 64'(d_dout); assign o_vld[3] = d_vld; assign o_rdy[3] = d_rdy;
  assign o_ovf[0] = a_ovf; assign o_ovf[1] = b_ovf; assign o_ovf[2] = c_ovf; assign o_ovf[3] = d_ovf;
  assign o_cnt[0] = {1'b0, a_cnt}; assign o_cnt[1] = b_cnt;
  assign o_cnt[2] = {1'b0, c_cnt}; assign o_cnt[3] = {1'b0, d_cnt};

  // ---------------- scoreboard bookkeeping ----------------
  int tests = 0;
  int errs  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint lane_val(input logic [63:0] v, input int lane, input int ow);
    logic [63:0] x;
    x = (v >> (lane * ow)) & ((64'd1 << ow) - 64'd1);
    if (x[ow-1]) return longint'(x) - (longint'(1) << ow);
    return longint'(x);
  endfunction

  // ---------------- behavioural model ----------------
  localparam int MDS  [4] = '{4, 8, 4, 4};
  localparam int OWS  [4] = '{10, 11, 8, 8};
  localparam int SATS [4] = '{0, 0, 1, 0};

  int       m_sum  [4][2];
  int       m_cnt  [4];
  int       m_eff  [4];
  bit       m_full [4];
  bit [1:0] m_ovf  [4];

  function automatic int fit(input int t, input int ow, input int sat);
    int mx, mn, r;
    mx = (1 << (ow - 1)) - 1;
    mn = -(1 << (ow - 1));
    if (t >= mn && t <= mx) return t;
    if (sat != 0) return (t > mx) ? mx : mn;
    r = t & ((1 << ow) - 1);
    if (r > mx) r = r - (1 << ow);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        m_cnt[k] = 0; m_full[k] = 0; m_ovf[k] = 0; m_eff[k] = 1;
        for (int i = 0; i < 2; i++) m_sum[k][i] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        int  dsee, lane_in, t, base;
        bit  rdy;
        bit [1:0] new_ovf;
        rdy = !clear && (!m_full[k] || out_ready);
        dsee = (k == 1) ? int'(depth) : int'(depth_n);
        if (clear) begin
          m_cnt[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
          for (int i = 0; i < 2; i++) m_sum[k][i] = 0;
        end else if (valid && rdy) begin
          if (m_full[k] || m_cnt[k] == 0)
            m_eff[k] = (dsee == 0) ? 1 : (dsee > MDS[k]) ? MDS[k] : dsee;
          new_ovf = 0;
          for (int i = 0; i < 2; i++) begin
            lane_in = int'($signed(data_in[8*i +: 8]));
            base = m_full[k] ? 0 : m_sum[k][i];
            t = base + lane_in;
            m_sum[k][i] = fit(t, OWS[k], SATS[k]);
            if (fit(t, OWS[k], 0) != t) new_ovf[i] = 1'b1;
          end
          m_ovf[k] = (m_full[k] ? 2'b00 : m_ovf[k]) | new_ovf;
          m_cnt[k] = m_full[k] ? 1 : m_cnt[k] + 1;
          m_full[k] = (m_cnt[k] == m_eff[k]);
        end else if (m_full[k] && out_ready) begin
          m_cnt[k] = 0; m_full[k] = 0; m_ovf[k] = 0;
          for (int i = 0; i < 2; i++) m_sum[k][i] = 0;
        end
      end
    end
  end

  // Every cycle: compare all instances against the model on the falling edge.
  always @(negedge clk) begin
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("m%0d.valid", k), longint'(o_vld[k]), longint'(m_full[k]));
      chk($sformatf("m%0d.ready", k), longint'(o_rdy[k]),
          longint'(!clear && (!m_full[k] || out_ready)));
      chk($sformatf("m%0d.counter", k), longint'(o_cnt[k]), longint'(m_cnt[k]));
      chk($sformatf("m%0d.overflow", k), longint'(o_ovf[k]), longint'(m_ovf[k]));
      if (m_full[k] || !rst) begin
        for (int i = 0; i < 2; i++)
          chk($sformatf("m%0d.lane%0d", k, i), lane_val(o_dout[k], i, OWS[k]),
              longint'(m_sum[k][i]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic beat(input int l0, input int l1);
    data_in = {8'(l1), 8'(l0)};
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit_lanes(input string name, input int k, input int e0, input int e1);
    chk({name, ".l0"}, lane_val(o_dout[k], 0, OWS[k]), longint'(e0));
    chk({name, ".l1"}, lane_val(o_dout[k], 1, OWS[k]), longint'(e1));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    repeat (3) @(negedge clk);
    chk("rst.valid", longint'(a_vld), 0);
    chk("rst.counter", longint'(a_cnt), 0);
    chk("rst.overflow", longint'(a_ovf), 0);
    chk("rst.dout", longint'(a_dout), 0);
    chk("rst.ready", longint'(a_rdy), 1);
    @(posedge clk); #1;
    rst = 1'b1;

    // Four beats of {1,-1}, output held downstream.
    out_ready = 1'b0;
    repeat (3) beat(1, -1);
    @(negedge clk);
    chk("blk4.early_valid", longint'(a_vld), 0);
    beat(1, -1);
    @(negedge clk);
    chk("blk4.valid", longint'(a_vld), 1);
    chk("blk4.counter", longint'(a_cnt), 4);
    chk("blk4.overflow", longint'(a_ovf), 0);
    lit_lanes("blk4", 0, 4, -4);

    // Stall in FULL for three cycles with a beat waiting.
    data_in = {8'(6), 8'(5)};
    valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) @(negedge clk);
      chk("stall.ready", longint'(a_rdy), 0);
      lit_lanes("stall", 0, 4, -4);
    end
    out_ready = 1'b1;
    beat(5, 6);
    @(negedge clk);
    chk("seed.counter", longint'(a_cnt), 1);
    repeat (3) beat(1, 1);
    @(negedge clk);
    lit_lanes("seed", 0, 8, 9);
    idle(1);

    // Back-to-back depth-2 blocks.
    depth = 4'd2;
    beat(1, 0);
    @(negedge clk); chk("b2b.cnt1", longint'(a_cnt), 1);
    beat(2, 0);
    @(negedge clk); chk("b2b.cnt2", longint'(a_cnt), 2); lit_lanes("b2b.out3", 0, 3, 0);
    chk("b2b.ready", longint'(a_rdy), 1);
    beat(3, 0);
    @(negedge clk); chk("b2b.cnt3", longint'(a_cnt), 1);
    beat(4, 0);
    @(negedge clk); chk("b2b.cnt4", longint'(a_cnt), 2); lit_lanes("b2b.out7", 0, 7, 0);
    idle(1);

    // Overflow: saturate vs wrap.
    beat(100, -100);
    beat(100, -100);
    @(negedge clk);
    lit_lanes("sat", 2, 127, -128);
    chk("sat.ovf", longint'(c_ovf), 3);
    lit_lanes("wrap", 3, -56, 56);
    chk("wrap.ovf", longint'(d_ovf), 3);
    lit_lanes("wide", 0, 200, -200);
    chk("wide.ovf", longint'(a_ovf), 0);
    idle(1);
    @(negedge clk);
    chk("ovf.cleared", longint'(d_ovf), 0);

    // Sticky overflow inside one block.
    depth = 4'd4;
    beat(100, 0); beat(100, 0); beat(1, 0);
    @(negedge clk);
    chk("sticky.mid", longint'(d_ovf), 1);
    beat(1, 0);
    @(negedge clk);
    lit_lanes("sticky", 3, -54, 0);
    chk("sticky.end", longint'(d_ovf), 1);
    lit_lanes("sticky.wide", 0, 202, 0);
    idle(1);

    // depth 0 behaves as depth 1.
    depth = 4'd0;
    beat(7, -3);
    @(negedge clk); chk("d0.valid", longint'(a_vld), 1); lit_lanes("d0.a", 0, 7, -3);
    beat(-8, 2);
    @(negedge clk); chk("d0.cnt", longint'(a_cnt), 1); lit_lanes("d0.b", 0, -8, 2);
    beat(127, -128);
    @(negedge clk); lit_lanes("d0.c", 1, 127, -128);

    // depth 9 clamps to MAX_DEPTH.
    depth = 4'd9;
    repeat (7) beat(1, 2);
    @(negedge clk);
    chk("d9.valid7", longint'(b_vld), 0);
    chk("d9.cnt7", longint'(b_cnt), 7);
    beat(1, 2);
    @(negedge clk);
    chk("d9.valid8", longint'(b_vld), 1);
    chk("d9.cnt8", longint'(b_cnt), 8);
    lit_lanes("d9", 1, 8, 16);
    chk("d9.small_cnt", longint'(a_cnt), 4);
    lit_lanes("d9.small", 0, 4, 8);
    idle(1);

    // clear after two beats; a depth change mid-block is ignored.
    depth = 4'd4;
    beat(3, 3);
    depth = 4'd1;
    beat(3, 3);
    @(negedge clk);
    chk("clr.pre_valid", longint'(a_vld), 0);
    chk("clr.pre_cnt", longint'(a_cnt), 2);
    clear = 1'b1;
    data_in = {8'(50), 8'(50)};
    valid = 1'b1;
    @(negedge clk);
    chk("clr.ready", longint'(a_rdy), 0);
    @(posedge clk); #1;
    clear = 1'b0;
    valid = 1'b0;
    @(negedge clk);
    chk("clr.cnt", longint'(a_cnt), 0);
    chk("clr.valid", longint'(a_vld), 0);
    chk("clr.dout", longint'(a_dout), 0);
    depth = 4'd4;
    repeat (3) beat(1, 2);
    @(negedge clk); chk("clr.fresh_early", longint'(a_vld), 0);
    beat(1, 2);
    @(negedge clk); lit_lanes("clr.fresh", 0, 4, 8);
    idle(1);

    // Reset pulse mid-block.
    beat(9, 9);
    beat(9, 9);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst.cnt", longint'(a_cnt), 0);
    chk("mrst.valid", longint'(a_vld), 0);
    chk("mrst.dout", longint'(a_dout), 0);
    chk("mrst.ready", longint'(a_rdy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (4) beat(2, -1);
    @(negedge clk);
    chk("mrst.fresh_valid", longint'(a_vld), 1);
    lit_lanes("mrst.fresh", 0, 8, -4);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
